// File: rtl/readreg.sv
`timescale 1ns/1ps
// Register-read stage between rename and issue: reads operands from the
// physical regfile, snoops writeback, and holds one bundle under stall/flush.
module readreg #(
  parameter int READREG_WIDTH    = 2,
  parameter int WB_WIDTH         = 2,
  parameter int PHY_REG_ID_WIDTH = 6,
  parameter int REG_DATA_WIDTH   = 32,
  parameter int PAYLOAD_WIDTH    = 64
) (
  input  logic                                                  clk,
  input  logic                                                  rst,
  input  logic [READREG_WIDTH-1:0]                              rename_readreg_valid,
  input  logic [READREG_WIDTH-1:0][PAYLOAD_WIDTH-1:0]           rename_readreg_payload,
  input  logic [READREG_WIDTH-1:0][1:0][PHY_REG_ID_WIDTH-1:0]   rename_readreg_src_id,
  input  logic [READREG_WIDTH-1:0][1:0]                         rename_readreg_src_en,
  output logic                                                  readreg_rename_stall,
  output logic [READREG_WIDTH-1:0][1:0][PHY_REG_ID_WIDTH-1:0]   readreg_phyf_id,
  input  logic [READREG_WIDTH-1:0][1:0][REG_DATA_WIDTH-1:0]     phyf_readreg_data,
  input  logic [READREG_WIDTH-1:0][1:0]                         phyf_readreg_data_valid,
  input  logic [WB_WIDTH-1:0][PHY_REG_ID_WIDTH-1:0]             wb_phyf_id,
  input  logic [WB_WIDTH-1:0][REG_DATA_WIDTH-1:0]               wb_phyf_data,
  input  logic [WB_WIDTH-1:0]                                   wb_phyf_we,
  output logic [READREG_WIDTH-1:0]                              readreg_issue_valid,
  output logic [READREG_WIDTH-1:0][PAYLOAD_WIDTH-1:0]           readreg_issue_payload,
  output logic [READREG_WIDTH-1:0][1:0][PHY_REG_ID_WIDTH-1:0]   readreg_issue_src_id,
  output logic [READREG_WIDTH-1:0][1:0][REG_DATA_WIDTH-1:0]     readreg_issue_src_data,
  output logic [READREG_WIDTH-1:0][1:0]                         readreg_issue_src_ready,
  input  logic                                                  issue_readreg_stall,
  input  logic                                                  commit_feedback_flush
);

  logic [READREG_WIDTH-1:0]                            valid_q, valid_d;
  logic [READREG_WIDTH-1:0][PAYLOAD_WIDTH-1:0]         payload_q, payload_d;
  logic [READREG_WIDTH-1:0][1:0][PHY_REG_ID_WIDTH-1:0] src_id_q, src_id_d;
  logic [READREG_WIDTH-1:0][1:0][REG_DATA_WIDTH-1:0]   src_data_q, src_data_d;
  logic [READREG_WIDTH-1:0][1:0]                       src_ready_q, src_ready_d;

  logic [READREG_WIDTH-1:0][1:0]                       ld_hit, hd_hit;
  logic [READREG_WIDTH-1:0][1:0][REG_DATA_WIDTH-1:0]   ld_data, hd_data;
  logic                                                load_en;

  assign load_en              = ~issue_readreg_stall & ~commit_feedback_flush;
  assign readreg_rename_stall = issue_readreg_stall;

  // Regfile read ids; the all-ones sentinel means "no read" (also during reset).
  always_comb begin
    readreg_phyf_id = '1;
    for (int i = 0; i < READREG_WIDTH; i++) begin
      for (int j = 0; j < 2; j++) begin
        if (rst && load_en && rename_readreg_valid[i] && rename_readreg_src_en[i][j])
          readreg_phyf_id[i][j] = rename_readreg_src_id[i][j];
      end
    end
  end

  // Writeback snoop for incoming ids (load) and held ids (wake-up); the lane
  // loop runs upward so the highest-numbered matching lane wins.
  always_comb begin
    // NOTE: every output of this block is defaulted first so no latch is inferred.
    ld_hit  = '0;
    ld_data = '0;
    hd_hit  = '0;
    hd_data = '0;
    for (int i = 0; i < READREG_WIDTH; i++) begin
      for (int j = 0; j < 2; j++) begin
        for (int w = 0; w < WB_WIDTH; w++) begin
          if (wb_phyf_we[w] && (wb_phyf_id[w] == rename_readreg_src_id[i][j])) begin
            ld_hit[i][j]  = 1'b1;
            ld_data[i][j] = wb_phyf_data[w];
          end
          if (wb_phyf_we[w] && (wb_phyf_id[w] == src_id_q[i][j])) begin
            hd_hit[i][j]  = 1'b1;
            hd_data[i][j] = wb_phyf_data[w];
          end
        end
      end
    end
  end

  always_comb begin
    valid_d     = valid_q;
    payload_d   = payload_q;
    src_id_d    = src_id_q;
    src_data_d  = src_data_q;
    src_ready_d = src_ready_q;
    if (commit_feedback_flush) begin
      valid_d     = '0;
      src_data_d  = '0;
      src_ready_d = '0;
    end else if (!issue_readreg_stall) begin
      valid_d   = rename_readreg_valid;
      payload_d = rename_readreg_payload;
      src_id_d  = rename_readreg_src_id;
      for (int i = 0; i < READREG_WIDTH; i++) begin
        for (int j = 0; j < 2; j++) begin
          if (!rename_readreg_src_en[i][j]) begin
            src_ready_d[i][j] = 1'b1;
            src_data_d[i][j]  = '0;
          end else if (ld_hit[i][j]) begin
            src_ready_d[i][j] = 1'b1;
            src_data_d[i][j]  = ld_data[i][j];
          end else if (phyf_readreg_data_valid[i][j]) begin
            src_ready_d[i][j] = 1'b1;
            src_data_d[i][j]  = phyf_readreg_data[i][j];
          end else begin
            src_ready_d[i][j] = 1'b0;
            src_data_d[i][j]  = '0;
          end
        end
      end
    end else begin
      for (int i = 0; i < READREG_WIDTH; i++) begin
        for (int j = 0; j < 2; j++) begin
          if (valid_q[i] && !src_ready_q[i][j] && hd_hit[i][j]) begin
            src_ready_d[i][j] = 1'b1;
            src_data_d[i][j]  = hd_data[i][j];
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
      valid_q     <= '0;
      src_data_q  <= '0;
      src_ready_q <= '0;
    end else begin
      valid_q     <= valid_d;
      src_data_q  <= src_data_d;
      src_ready_q <= src_ready_d;
    end
  end

  // NOTE: payload and ids are pure datapath; outputs are masked by valid_q,
  // so these registers are deliberately left without reset.
  always_ff @(posedge clk) begin
    payload_q <= payload_d;
    src_id_q  <= src_id_d;
  end

  // Invalid slots present all-zero fields to issue.
  always_comb begin
    readreg_issue_valid     = valid_q;
    readreg_issue_payload   = '0;
    readreg_issue_src_id    = '0;
    readreg_issue_src_data  = '0;
    readreg_issue_src_ready = '0;
    for (int i = 0; i < READREG_WIDTH; i++) begin
      if (valid_q[i]) begin
        readreg_issue_payload[i]   = payload_q[i];
        readreg_issue_src_id[i]    = src_id_q[i];
        readreg_issue_src_data[i]  = src_data_q[i];
        readreg_issue_src_ready[i] = src_ready_q[i];
      end
    end
  end

endmodule
